pipelined_rca: RTL and testbench



---
 rtl/pipelined_rca.sv | 120 ++++++++++++
 tb/tb_pipelined_rca.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder: {Cout,S} = A + B + Cin, carry chain cut into STAGES registered slices.
// Latency STAGES cycles; stalls as a whole when out_valid & ~out_ready; define PIPE_RCA_OVF_EN for Ovf.
module pipelined_rca #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef PIPE_RCA_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CHUNK = (STAGES > 0) ? WIDTH / STAGES : 1;

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH ||
      ((STAGES > 0) ? (WIDTH % STAGES) : 1) != 0) begin : g_bad_params
    $error("pipelined_rca: STAGES must divide WIDTH with 1 <= STAGES <= WIDTH");
  end

  logic adv;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Stage k sees only the operand bits not yet consumed, LSB-aligned.
    localparam int SRC = WIDTH - k * CHUNK;
    localparam int LO  = k * CHUNK;

    logic [SRC-1:0]      a_src;
    logic [SRC-1:0]      b_src;
    logic                c_src;
    logic                v_src;
    logic [CHUNK:0]      part;
    logic [LO+CHUNK-1:0] s_next;
    logic                v_q;
    logic                c_q;
    logic [LO+CHUNK-1:0] s_q;

    if (k == 0) begin : g_head
      assign a_src  = A;
      assign b_src  = B;
      assign c_src  = Cin;
      assign v_src  = in_valid;
      assign s_next = part[CHUNK-1:0];
    end else begin : g_body
      assign a_src  = g_stage[k-1].g_fwd.a_q;
      assign b_src  = g_stage[k-1].g_fwd.b_q;
      assign c_src  = g_stage[k-1].c_q;
      assign v_src  = g_stage[k-1].v_q;
      assign s_next = {part[CHUNK-1:0], g_stage[k-1].s_q};
    end

    assign part = {1'b0, a_src[CHUNK-1:0]} + {1'b0, b_src[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_src};

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_src;
        c_q <= part[CHUNK];
        s_q <= s_next;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      localparam int REM = SRC - CHUNK;

      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_src[SRC-1:CHUNK];
          b_q <= b_src[SRC-1:CHUNK];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign S         = g_stage[STAGES-1].s_q;
  assign Cout      = g_stage[STAGES-1].c_q;

`ifdef PIPE_RCA_OVF_EN
  // Carry into the MSB is recovered from the MSB sum bit: a ^ b ^ s.
  logic ovf_q;
  logic msb_cin;

  assign msb_cin = g_stage[STAGES-1].a_src[CHUNK-1] ^ g_stage[STAGES-1].b_src[CHUNK-1] ^
                   g_stage[STAGES-1].part[CHUNK-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= msb_cin ^ g_stage[STAGES-1].part[CHUNK];
    end
  end

  assign Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_rca.sv
// Scoreboard bench for pipelined_rca (WIDTH=8, STAGES=2) with directed vectors.
module tb_pipelined_rca;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] S;
  logic       Cout;
`ifdef PIPE_RCA_OVF_EN
  logic       Ovf;
`endif

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp_t;

  exp_t q[$];
  int   n_chk;
  int   n_fail;
  int   n_out;

  pipelined_rca #(.WIDTH(8), .STAGES(2)) dut (
`ifdef PIPE_RCA_OVF_EN
    .Ovf      (Ovf),
`endif
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .S        (S),
    .Cout     (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per output transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_out++;
        if (q.size() == 0) begin
          chk("unexpected_output", 32'(S), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("result_S", 32'(S), 32'(e.s));
          chk("result_Cout", 32'(Cout), 32'(e.c));
`ifdef PIPE_RCA_OVF_EN
          chk("result_Ovf", 32'(Ovf), 32'(e.o));
`endif
        end
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] s, input logic co, input logic ov, input bit push);
    bit accepted;
    accepted = 0;
    @(posedge clk);
    #1;
    A = a; B = b; Cin = c; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1;
        if (push) q.push_back('{s: s, c: co, o: ov});
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("send_accept", 32'(accepted), 32'd1);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int target, input string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (n_out >= target) break;
    end
    chk(name, 32'(n_out), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    n_chk = 0; n_fail = 0; n_out = 0;

    // Reset with random live inputs
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    A = 8'($urandom); B = 8'($urandom); Cin = 1'($urandom);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_S", 32'(S), 32'd0);
    chk("reset_Cout", 32'(Cout), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // Single op with latency and single-pulse checks
    send(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1);
    idle();
    @(negedge clk); chk("lat_early", 32'(out_valid), 32'd0);
    @(negedge clk); chk("lat_on", 32'(out_valid), 32'd1);
    @(negedge clk); chk("lat_single_pulse", 32'(out_valid), 32'd0);
    send(8'hCC, 8'h33, 1'b1, 8'h00, 1'b1, 1'b0, 1);
    idle();
    wait_out(2, "single_count");

    // Back-to-back stream, results must be gap-free
    send(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1);
    send(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1);
    send(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1);
    chk("stream_v0", 32'(out_valid), 32'd1);
    idle();
    @(negedge clk); chk("stream_v1", 32'(out_valid), 32'd1);
    @(negedge clk); chk("stream_v2", 32'(out_valid), 32'd1);
    @(negedge clk); chk("stream_end", 32'(out_valid), 32'd0);
    wait_out(5, "stream_count");

    // Backpressure: fill, stall 3 cycles, release
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1);
    send(8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0, 1);
    @(posedge clk);
    #1;
    A = 8'hAA; B = 8'h55; Cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_S", 32'(S), 32'h46);
      chk("stall_Cout", 32'(Cout), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    q.push_back('{s: 8'h00, c: 1'b1, o: 1'b0});
    idle();
    wait_out(8, "drain_count");

    // Signed overflow vectors (S/Cout always checked)
    send(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1);
    send(8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1, 1);
    send(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1);
    idle();
    wait_out(11, "ovf_count");

    // Reset one cycle after issue: no result may emerge
    base = n_out;
    send(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    end

    // Reset while stalled with a full pipe
    out_ready = 1'b0;
    send(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 0);
    send(8'h04, 8'h05, 1'b0, 8'h09, 1'b0, 1'b0, 0);
    idle();
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_stall_out_valid", 32'(out_valid), 32'd0);
    end
    chk("rst_no_output", 32'(n_out), 32'(base));
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
